// File: rtl/sof_controller_pkg.sv
// Shared host-controller definitions: TX-port command codes, SOF timing defaults
// and the SOF generator state encoding.
package sof_controller_pkg;

    localparam int SOF_PERIOD_DEF = 48000;
    localparam int TIMER_W_DEF    = 16;
    localparam int FRAME_W        = 11;

    // TX-port command codes; the SOF generator only issues the two SOF codes
    localparam logic [7:0] TX_CMD_IDLE    = 8'h00;
    localparam logic [7:0] TX_CMD_DATA    = 8'h01;
    localparam logic [7:0] TX_CMD_LS_PRE  = 8'h02;
    localparam logic [7:0] TX_CMD_RESUME  = 8'h03;
    localparam logic [7:0] SOF_CMD_LO     = 8'h04;
    localparam logic [7:0] SOF_CMD_HI     = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_GNT  = 3'd1,
        ST_WAIT_RDY1 = 3'd2,
        ST_WAIT_RDY2 = 3'd3,
        ST_DONE      = 3'd4
    } sof_state_e;

    function automatic logic [7:0] sof_hi_byte(input logic [FRAME_W-1:0] frame);
        return {5'b0, frame[10:8]};
    endfunction

endpackage

// File: rtl/sof_controller_if.sv
// SOF generator channel: control inputs, arbiter/TX-port handshake and status outputs.
interface sof_controller_if
    import sof_controller_pkg::*;
#(
    parameter int TIMER_W = TIMER_W_DEF
);
    logic               SOFEnable;
    logic               SOFTimerClr;
    logic               SOFCntlGnt;
    logic               HCTxPortRdy;
    logic               SOFCntlReq;
    logic               SOFCntlWEn;
    logic [7:0]         SOFCntlData;
    logic [7:0]         SOFCntlCntl;
    logic [FRAME_W-1:0] frameNum;
    logic [TIMER_W-1:0] SOFTimer;
    logic               SOFSent;
    logic               SOFOverrun;

    modport slave (
        input  SOFEnable, SOFTimerClr, SOFCntlGnt, HCTxPortRdy,
        output SOFCntlReq, SOFCntlWEn, SOFCntlData, SOFCntlCntl,
        output frameNum, SOFTimer, SOFSent, SOFOverrun
    );

    modport master (
        output SOFEnable, SOFTimerClr, SOFCntlGnt, HCTxPortRdy,
        input  SOFCntlReq, SOFCntlWEn, SOFCntlData, SOFCntlCntl,
        input  frameNum, SOFTimer, SOFSent, SOFOverrun
    );
endinterface

// File: rtl/sof_controller_frame_timer.sv
// 1 ms frame timer: counts 0..SOF_PERIOD-1 while enabled and flags the frame boundary.
module sof_frame_timer
    import sof_controller_pkg::*;
#(
    parameter int SOF_PERIOD = SOF_PERIOD_DEF,
    parameter int TIMER_W    = TIMER_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               clr_i,
    output logic [TIMER_W-1:0] timer_o,
    output logic               sof_due_o
);
    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(SOF_PERIOD - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               at_last;

    assign at_last = (timer_q == LAST);

    always_comb begin
        timer_d = timer_q + TIMER_W'(1);
        if (clr_i || !en_i || at_last) timer_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
    end

    // A clear landing on the boundary cycle suppresses that frame's SOF
    assign sof_due_o = en_i && at_last && !clr_i;
    assign timer_o   = timer_q;

endmodule

// File: rtl/sof_controller.sv
// Host Start-Of-Frame generator: requests the TX port at each frame boundary and
// writes the two-byte SOF command carrying the 11-bit frame number.
module sof_controller
    import sof_controller_pkg::*;
#(
    parameter int SOF_PERIOD = SOF_PERIOD_DEF,
    parameter int TIMER_W    = TIMER_W_DEF
) (
    input logic             clk,
    input logic             rst,
    sof_controller_if.slave bus
);
    sof_state_e         state_q, state_d;
    logic               req_q, req_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               wen_q;
    logic               wen;
    logic [7:0]         data;
    logic [7:0]         cntl;
    logic               sent;
    logic               sof_due;
    logic [TIMER_W-1:0] timer;

    sof_frame_timer #(
        .SOF_PERIOD (SOF_PERIOD),
        .TIMER_W    (TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .en_i      (bus.SOFEnable),
        .clr_i     (bus.SOFTimerClr),
        .timer_o   (timer),
        .sof_due_o (sof_due)
    );

    // A boundary that arrives while an SOF is still outstanding is dropped, not queued
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (state_q == ST_IDLE && pending_q) pending_d = 1'b0;
        if (sof_due) begin
            if (pending_q || state_q != ST_IDLE) overrun_d = 1'b1;
            else                                  pending_d = 1'b1;
        end
        if (!bus.SOFEnable) pending_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        frame_d = frame_q;
        wen     = 1'b0;
        data    = 8'h00;
        cntl    = 8'h00;
        sent    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d = ST_WAIT_GNT;
                    req_d   = 1'b1;
                end
            end
            ST_WAIT_GNT: begin
                if (bus.SOFCntlGnt) state_d = ST_WAIT_RDY1;
            end
            ST_WAIT_RDY1: begin
                if (!bus.SOFCntlGnt) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end else if (bus.HCTxPortRdy) begin
                    wen     = 1'b1;
                    cntl    = SOF_CMD_LO;
                    data    = frame_q[7:0];
                    state_d = ST_WAIT_RDY2;
                end
            end
            ST_WAIT_RDY2: begin
                // The port lowers Rdy one cycle late, so Rdy right after a write is stale
                if (!bus.SOFCntlGnt) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end else if (bus.HCTxPortRdy && !wen_q) begin
                    wen     = 1'b1;
                    cntl    = SOF_CMD_HI;
                    data    = sof_hi_byte(frame_q);
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                end
            end
            ST_DONE: begin
                sent    = 1'b1;
                frame_d = frame_q + FRAME_W'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            frame_q   <= '0;
            wen_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            frame_q   <= frame_d;
            wen_q     <= wen;
        end
    end

    assign bus.SOFCntlReq  = req_q;
    assign bus.SOFCntlWEn  = wen;
    assign bus.SOFCntlData = data;
    assign bus.SOFCntlCntl = cntl;
    assign bus.frameNum    = frame_q;
    assign bus.SOFTimer    = timer;
    assign bus.SOFSent     = sent;
    assign bus.SOFOverrun  = overrun_q;

endmodule

// File: tb/tb_sof_controller.sv
// Directed bench for sof_controller with a write scoreboard and a one-cycle-lag arbiter model.
`timescale 1ns/1ps
module tb_sof_controller;
    import sof_controller_pkg::*;

    localparam int PERIOD = 20;
    localparam int TW     = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sof_controller_if #(.TIMER_W(TW)) bus();

    sof_controller #(
        .SOF_PERIOD (PERIOD),
        .TIMER_W    (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          tests    = 0;
    int          fails    = 0;
    int          cyc      = 0;
    int          sent_cnt = 0;
    int          base;
    logic [15:0] exp_q[$];
    logic        gnt_auto = 1'b0;
    logic        req_d1   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic push_sof(input logic [10:0] f, input bit both);
        exp_q.push_back({8'h04, f[7:0]});
        if (both) exp_q.push_back({8'h05, 5'b0, f[10:8]});
    endtask

    task automatic chk_reset(input string p);
        check({p, "_req"},     32'(bus.SOFCntlReq),  32'd0);
        check({p, "_wen"},     32'(bus.SOFCntlWEn),  32'd0);
        check({p, "_data"},    32'(bus.SOFCntlData), 32'd0);
        check({p, "_cntl"},    32'(bus.SOFCntlCntl), 32'd0);
        check({p, "_frame"},   32'(bus.frameNum),    32'd0);
        check({p, "_timer"},   32'(bus.SOFTimer),    32'd0);
        check({p, "_sent"},    32'(bus.SOFSent),     32'd0);
        check({p, "_overrun"}, 32'(bus.SOFOverrun),  32'd0);
    endtask

    // Arbiter model: grant follows request with one cycle of lag
    always @(negedge clk) begin
        bus.SOFCntlGnt = gnt_auto && req_d1;
        req_d1         = bus.SOFCntlReq;
    end

    // Write monitor: every strobe must be granted and match the next expected write
    always @(posedge clk) begin
        logic [15:0] exp_w;
        #2;
        if (rst === 1'b0) begin
            if (bus.SOFSent === 1'b1) sent_cnt++;
            if (bus.SOFCntlWEn === 1'b1) begin
                check("wen_needs_gnt", 32'(bus.SOFCntlGnt), 32'd1);
                check("sb_write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    check("sb_write", 32'({bus.SOFCntlCntl, bus.SOFCntlData}), 32'(exp_w));
                end
            end else begin
                check("idle_bus_zero", 32'({bus.SOFCntlCntl, bus.SOFCntlData}), 32'd0);
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.SOFEnable   = 1'b0;
        bus.SOFTimerClr = 1'b0;
        bus.HCTxPortRdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");

        // Basic frame: Req at 21, writes at 23 and 25, Sent at 26
        rst = 1'b0;
        bus.SOFEnable   = 1'b1;
        bus.HCTxPortRdy = 1'b1;
        gnt_auto = 1'b1;
        cyc = 0;
        push_sof(11'd0, 1'b1);
        goto(5);   check("timer_count", 32'(bus.SOFTimer), 32'd5);
        goto(20);  check("req_c20", 32'(bus.SOFCntlReq), 32'd0);
        goto(21);  check("req_c21", 32'(bus.SOFCntlReq), 32'd1);
        goto(23);  check("wen_lo_c23", 32'(bus.SOFCntlWEn), 32'd1);
                   check("cntl_lo_c23", 32'(bus.SOFCntlCntl), 32'h04);
        goto(24);  check("wen_gap_c24", 32'(bus.SOFCntlWEn), 32'd0);
        goto(25);  check("wen_hi_c25", 32'(bus.SOFCntlWEn), 32'd1);
                   check("cntl_hi_c25", 32'(bus.SOFCntlCntl), 32'h05);
        goto(26);  check("sent_c26", 32'(bus.SOFSent), 32'd1);
                   check("req_done_c26", 32'(bus.SOFCntlReq), 32'd0);
        goto(27);  check("frame_after1", 32'(bus.frameNum), 32'd1);

        // Rdy held low after grant
        bus.HCTxPortRdy = 1'b0;
        push_sof(11'd1, 1'b1);
        goto(41);  check("req_c41", 32'(bus.SOFCntlReq), 32'd1);
        goto(52);  check("req_held_rdy0", 32'(bus.SOFCntlReq), 32'd1);
                   check("no_wen_rdy0", 32'(bus.SOFCntlWEn), 32'd0);
        goto(53);
        bus.HCTxPortRdy = 1'b1;
        #1;        check("wen_on_rdy", 32'(bus.SOFCntlWEn), 32'd1);
                   check("data_on_rdy", 32'(bus.SOFCntlData), 32'h01);
        goto(54);  check("stale_rdy_ignored", 32'(bus.SOFCntlWEn), 32'd0);
        goto(55);  check("wen_hi_c55", 32'(bus.SOFCntlWEn), 32'd1);
        goto(57);  check("frame_after2", 32'(bus.frameNum), 32'd2);

        // Clear on the boundary cycle skips that frame's SOF
        push_sof(11'd2, 1'b1);
        goto(67);  check("frame_after3", 32'(bus.frameNum), 32'd3);
        goto(79);  check("timer_c79", 32'(bus.SOFTimer), 32'd19);
        bus.SOFTimerClr = 1'b1;
        goto(80);
        bus.SOFTimerClr = 1'b0;
                   check("timer_cleared", 32'(bus.SOFTimer), 32'd0);
        goto(81);  check("no_sof_after_clr", 32'(bus.SOFCntlReq), 32'd0);
        push_sof(11'd3, 1'b1);
        goto(100); check("req_c100", 32'(bus.SOFCntlReq), 32'd0);
        goto(101); check("req_c101", 32'(bus.SOFCntlReq), 32'd1);
        goto(107); check("frame_after4", 32'(bus.frameNum), 32'd4);

        // Grant withheld across a frame boundary
        goto(110);
        gnt_auto = 1'b0;
        push_sof(11'd4, 1'b1);
        goto(121); check("req_c121", 32'(bus.SOFCntlReq), 32'd1);
        goto(139); check("overrun_c139", 32'(bus.SOFOverrun), 32'd0);
                   check("no_wen_nognt", 32'(bus.SOFCntlWEn), 32'd0);
        goto(140); check("overrun_c140", 32'(bus.SOFOverrun), 32'd1);
        goto(141);
        gnt_auto = 1'b1;
        base = sent_cnt;
        goto(158); check("one_sof_after_gnt", 32'(sent_cnt - base), 32'd1);
                   check("frame_after_ovr", 32'(bus.frameNum), 32'd5);
        push_sof(11'd5, 1'b1);
        goto(167); check("frame_after6", 32'(bus.frameNum), 32'd6);
        goto(170); check("overrun_sticky", 32'(bus.SOFOverrun), 32'd1);

        // Asynchronous reset in the cycle after the low-byte write
        push_sof(11'd6, 1'b0);
        goto(184);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        goto(186);
        rst = 1'b0;
        goto(201); check("no_req_after_rst", 32'(bus.SOFCntlReq), 32'd0);
                   check("frame_after_rst", 32'(bus.frameNum), 32'd0);
                   check("sb_drained_rst", 32'(exp_q.size()), 32'd0);
        bus.SOFEnable = 1'b0;
        goto(203); check("timer_held_dis", 32'(bus.SOFTimer), 32'd0);

        // Run 2048 frames so the frame number wraps 2047 -> 0
        for (int f = 0; f < 2048; f++) push_sof(11'(f), 1'b1);
        bus.SOFEnable = 1'b1;
        base = sent_cnt;
        for (int i = 0; i < 2048 * PERIOD + 200 && (sent_cnt - base) < 2048; i++) step();
        bus.SOFEnable = 1'b0;
        check("wrap_sent_count", 32'(sent_cnt - base), 32'd2048);
        step();
        check("frame_wrapped", 32'(bus.frameNum), 32'd0);
        check("sb_drained_wrap", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
